// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for the EX stage (DIV/DIVU).
// Produces {remainder, quotient} after 32 iterations with a ready handshake.
module ex_div #(
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signed_div_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic                  start_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  ready_o
);

   typedef enum logic [1:0] {
      ST_FREE,
      ST_BYZERO,
      ST_ON,
      ST_END
   } state_t;

   state_t              state;
   logic [5:0]          cnt;
   logic [DATA_W-1:0]   rem;
   logic [DATA_W-1:0]   quo;
   logic [DATA_W-1:0]   dvs;
   logic                neg_q;
   logic                neg_r;

   logic [DATA_W-1:0]   a_abs;
   logic [DATA_W-1:0]   b_abs;
   logic [DATA_W:0]     rem_sh;
   logic [DATA_W:0]     diff;
   logic [DATA_W-1:0]   rem_nx;
   logic [DATA_W-1:0]   quo_nx;
   logic [DATA_W-1:0]   q_fin;
   logic [DATA_W-1:0]   r_fin;

   // The 65-bit working register is kept as a 32-bit remainder plus quotient:
   // after each restore step the remainder is below the divisor, so bit 32 is always 0.
   always_comb begin
      a_abs  = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
      b_abs  = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
      rem_sh = {rem, quo[DATA_W-1]};
      diff   = rem_sh - {1'b0, dvs};
      if (!diff[DATA_W]) begin
         rem_nx = diff[DATA_W-1:0];
         quo_nx = {quo[DATA_W-2:0], 1'b1};
      end else begin
         rem_nx = rem_sh[DATA_W-1:0];
         quo_nx = {quo[DATA_W-2:0], 1'b0};
      end
      q_fin = neg_q ? -quo_nx : quo_nx;
      r_fin = neg_r ? -rem_nx : rem_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_FREE;
         cnt      <= '0;
         rem      <= '0;
         quo      <= '0;
         dvs      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         case (state)
            ST_FREE: begin
               result_o <= '0;
               ready_o  <= 1'b0;
               if (start_i && !annul_i) begin
                  if (opdata2_i == '0) begin
                     state <= ST_BYZERO;
                  end else begin
                     state <= ST_ON;
                     cnt   <= '0;
                     rem   <= '0;
                     quo   <= a_abs;
                     dvs   <= b_abs;
                     neg_q <= signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                     neg_r <= signed_div_i && opdata1_i[DATA_W-1];
                  end
               end
            end
            ST_BYZERO: begin
               if (annul_i || !start_i) begin
                  state <= ST_FREE;
               end else begin
                  state    <= ST_END;
                  result_o <= '0;
                  ready_o  <= 1'b1;
               end
            end
            ST_ON: begin
               if (annul_i || !start_i) begin
                  state    <= ST_FREE;
                  result_o <= '0;
                  ready_o  <= 1'b0;
               end else begin
                  rem <= rem_nx;
                  quo <= quo_nx;
                  cnt <= cnt + 6'd1;
                  if (cnt == 6'(DATA_W - 1)) begin
                     state    <= ST_END;
                     result_o <= {r_fin, q_fin};
                     ready_o  <= 1'b1;
                  end
               end
            end
            ST_END: begin
               if (!start_i) begin
                  state    <= ST_FREE;
                  result_o <= '0;
                  ready_o  <= 1'b0;
               end
            end
            default: state <= ST_FREE;
         endcase
      end
   end

endmodule

// File: doc/ex_div.md
# ex_div

Iterative 32-bit divider attached to the EX stage of the five-stage MIPS pipeline. It consumes the source operands and operation delivered by the ID/EX register, and runs a radix-2 restoring division over 32 cycles. It returns a 64-bit {remainder, quotient} result with a ready handshake. While a division is in flight the EX stage holds its stall request, so the ID/EX register keeps presenting the same DIV/DIVU instruction until `ready_o` rises.

## Interface
- `DATA_W`, 32, operand width; quotient and remainder are each `DATA_W` bits.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high (`RstEnable` = 1).
- `signed_div_i`  in  1  1 = DIV (signed), 0 = DIVU (unsigned); sampled at start acceptance.
- `opdata1_i`  in  32  dividend; sampled at start acceptance.
- `opdata2_i`  in  32  divisor; sampled at start acceptance.
- `start_i`  in  1  request; held high by EX for the whole operation, dropped after `ready_o` is seen.
- `annul_i`  in  1  cancel an in-flight division (pipeline flush).
- `result_o`  out  64  {remainder[63:32], quotient[31:0]}; valid only while `ready_o`=1, otherwise 0.
- `ready_o`  out  1  result valid.

## Operation
- Four states: FREE, BYZERO, ON, END.
- **FREE**
  - If `start_i`=1 and `annul_i`=0 and divisor==0: go to BYZERO.
  - If `start_i`=1 and `annul_i`=0 and divisor!=0: latch operands, clear `cnt` (6 bits), and go to ON.
  - Otherwise stay in FREE.
- **Operand latch for signed division**
  - Take |dividend| and |divisor| (two's-complement negate when bit 31 is set).
  - Record `neg_q` = dividend[31] XOR divisor[31] and `neg_r` = dividend[31].
  - For unsigned division both flags are 0 and the raw values are used.
- **ON**
  - If `annul_i`=1 or `start_i`=0: go to FREE with no result and `ready_o` held at 0.
  - Otherwise perform one iteration on a 65-bit working register `{rem[32:0], quo[31:0]}`:
    - Shift left by 1.
    - Trial-subtract the divisor from `rem`.
    - If the difference is non-negative, keep it and set quotient bit 0 to 1; else restore and set it to 0.
    - Increment `cnt`.
  - On the iteration that brings `cnt` to 32: go to END.
    - Register `result_o` = {r', q'}, where q' = neg_q ? -quo : quo and r' = neg_r ? -rem : rem, both truncated to 32 bits.
    - Set `ready_o`=1.
- **BYZERO**
  - If `annul_i`=1 or `start_i`=0: go to FREE.
  - Otherwise go to END with `result_o`=0 and `ready_o`=1.
- **END**
  - Hold `result_o` and `ready_o`=1 while `start_i`=1.
  - When `start_i`=0: next edge goes to FREE with `result_o`=0 and `ready_o`=0.
  - `annul_i` is ignored in END.
- **Arithmetic rules**
  - Signed overflow −2^31 / −1 gives quotient 0x80000000 (wrapped) and remainder 0.
  - The remainder sign always follows the dividend; a zero remainder is never negated to nonzero.
- Operand input changes after acceptance have no effect.

## Timing
- Reset (`rst`=1 at an edge, in any state including mid-ON) forces:
  - State FREE, `cnt`=0, working register 0.
  - `result_o`=0 and `ready_o`=0 in the following cycle.
  - Reset overrides `start_i` and `annul_i`.
- Call the edge at which FREE accepts `start_i` E0.
  - Nonzero divisor: iterations occur at E1..E32; `ready_o` is first high in the cycle after E32, i.e. 33 edges after acceptance.
  - Zero divisor: `ready_o` is first high in the cycle after E1.
- Handshake:
  - `ready_o` stays high until the edge after `start_i` falls.
  - `start_i` reasserted in the same cycle as `ready_o` simply holds END; a new operation needs at least one FREE cycle.
- Abort: `annul_i`=1 at any edge in ON or BYZERO means FREE in the next cycle and `ready_o` never asserts for that operation.
- Back-to-back: with `start_i` dropped for one cycle after `ready_o`, the next acceptance can occur at the following edge. Minimum spacing between acceptances is 35 edges.

## Test plan
- DIVU 100 / 7, `start_i` held → `ready_o` after exactly 33 edges; `result_o` = {0x00000002, 0x0000000E}; drop `start_i` → `ready_o`=0, `result_o`=0 next cycle.
- DIV −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. DIVU 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Divisor 0 (DIVU 5 / 0) → `ready_o` after 2 edges; `result_o`=0.
- Start DIVU 100 / 7, assert `annul_i` at iteration 10 → FREE next cycle; `ready_o` stays 0 for 40 cycles. A new DIVU 9 / 3 then gives {0, 3} after 33 edges.
- Assert `rst` at iteration 20 with `start_i` still high → `ready_o`=0 and `result_o`=0. Release `rst` with `start_i` high → the division restarts from E0 and completes 33 edges later.
